// File: rtl/load_align_unit.sv
// Sequential load path: issues one or two aligned bus beats for a load and returns
// the little-endian, sign/zero-extended result to writeback over a valid/ready handshake.
module load_align_unit #(
  parameter int XLEN               = 32,
  parameter bit BUS_BIG_ENDIAN     = 1'b1,
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_fn3,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [2:0]        fn3_q, fn3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              wb_fault_q, wb_fault_d;

  logic              req_fault;
  logic              split;
  logic [OFFW-1:0]   cur_off;
  int                cur_bytes;
  logic [XLEN-1:0]   aligned_addr;
  logic [XLEN-1:0]   first_beat;
  logic [2*XLEN-1:0] buf_le;
  logic [2*XLEN-1:0] shifted;
  logic              sign_bit;
  logic [XLEN-1:0]   assembled;

  // Decode of the incoming request (fault) and of the latched one (split, offset).
  always_comb begin
    req_fault = ((req_fn3[1:0] == 2'd3) && (XLEN == 32)) ||
                (!SUPPORT_MISALIGNED &&
                 ((int'(req_addr[OFFW-1:0]) + (1 << req_fn3[1:0])) > NB));
    cur_off      = addr_q[OFFW-1:0];
    cur_bytes    = 1 << fn3_q[1:0];
    split        = (int'(cur_off) + cur_bytes) > NB;
    aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Byte buffer in little-endian order: beat0 bytes, then beat1 bytes. The beat
  // arriving now is beat0 in WAIT0 and beat1 in WAIT1.
  always_comb begin
    first_beat = (state_q == S_WAIT0) ? mem_rsp_data : beat0_q;
    buf_le     = '0;
    for (int k = 0; k < NB; k++) begin
      if (BUS_BIG_ENDIAN) begin
        buf_le[8*k +: 8]      = first_beat[XLEN-1-8*k -: 8];
        buf_le[8*(NB+k) +: 8] = mem_rsp_data[XLEN-1-8*k -: 8];
      end else begin
        buf_le[8*k +: 8]      = first_beat[8*k +: 8];
        buf_le[8*(NB+k) +: 8] = mem_rsp_data[8*k +: 8];
      end
    end
    shifted  = buf_le >> {cur_off, 3'b000};
    sign_bit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == cur_bytes - 1) sign_bit = shifted[8*i+7];
    end
    assembled = '0;
    for (int b = 0; b < XLEN; b++) begin
      if (b < 8 * cur_bytes) assembled[b] = shifted[b];
      else                   assembled[b] = fn3_q[2] ? 1'b0 : sign_bit;
    end
  end

  // NOTE: every _d gets its hold value first so no path through the case leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fn3_d      = fn3_q;
    rd_d       = rd_q;
    beat0_d    = beat0_q;
    wb_data_d  = wb_data_q;
    wb_fault_d = wb_fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          fn3_d  = req_fn3;
          rd_d   = req_rd;
          if (req_fault) begin
            state_d    = S_DONE;
            wb_fault_d = 1'b1;
            wb_data_d  = '0;
          end else begin
            state_d    = S_REQ0;
            wb_fault_d = 1'b0;
          end
        end
      end
      S_REQ0: if (mem_req_ready) state_d = S_WAIT0;
      S_WAIT0: begin
        if (mem_rsp_valid) begin
          beat0_d = mem_rsp_data;
          if (split) begin
            state_d = S_REQ1;
          end else begin
            state_d   = S_DONE;
            wb_data_d = assembled;
          end
        end
      end
      S_REQ1: if (mem_req_ready) state_d = S_WAIT1;
      S_WAIT1: begin
        if (mem_rsp_valid) begin
          state_d   = S_DONE;
          wb_data_d = assembled;
        end
      end
      S_DONE: begin
        if (wb_ready) begin
          state_d    = S_IDLE;
          wb_fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      fn3_q      <= '0;
      rd_q       <= '0;
      beat0_q    <= '0;
      wb_data_q  <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fn3_q      <= fn3_d;
      rd_q       <= rd_d;
      beat0_q    <= beat0_d;
      wb_data_q  <= wb_data_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
    mem_req_addr  = '0;
    if (state_q == S_REQ0) mem_req_addr = aligned_addr;
    if (state_q == S_REQ1) mem_req_addr = aligned_addr + XLEN'(NB);
    wb_valid      = (state_q == S_DONE);
    wb_data       = wb_data_q;
    wb_rd         = rd_q;
    wb_fault      = wb_fault_q;
  end

endmodule
